// File: rtl/cpu_pkg.sv
// Shared opcodes, controller state encoding and instruction field helpers for the 16-bit RISC core.
// Pure definitions: no logic, no latency, no flow control.
package cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_LUI  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BLT  = 4'hA;
    localparam logic [3:0] OP_BGT  = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_HALT
    } ctrl_state_t;

    function automatic logic [3:0] ir_op(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [3:0] ir_a(input logic [15:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [3:0] ir_b(input logic [15:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] ir_c(input logic [15:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [15:0] sext4(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: ALU select, register addresses and class flags from ir.
// Zero latency; no flow control, outputs follow ir directly.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  aluop,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [3:0]  wa,
    output logic        is_r,
    output logic        is_s,
    output logic        is_br,
    output logic        is_ld,
    output logic        is_st,
    output logic        is_jmp,
    output logic        is_halt
);

    logic [3:0] op;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [3:0] fc;

    assign op = ir_op(ir);
    assign fa = ir_a(ir);
    assign fb = ir_b(ir);
    assign fc = ir_c(ir);

    always_comb begin
        is_r    = 1'b0;
        is_s    = 1'b0;
        is_br   = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_jmp  = 1'b0;
        is_halt = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR:          is_r    = 1'b1;
            OP_ADDI, OP_SLL, OP_SRL, OP_SRA, OP_LUI: is_s    = 1'b1;
            OP_BEQ, OP_BLT, OP_BGT:                  is_br   = 1'b1;
            OP_LD:                                   is_ld   = 1'b1;
            OP_ST:                                   is_st   = 1'b1;
            OP_JMP:                                  is_jmp  = 1'b1;
            OP_HALT:                                 is_halt = 1'b1;
            default: ;
        endcase

        aluop = (is_jmp || is_halt) ? 4'h0 : op;
        // Branches compare a against b; every other ALU user takes its base/rs from b.
        ra1   = is_br ? fa : ((is_jmp || is_halt) ? 4'h0 : fb);
        ra2   = is_r ? fc : (is_br ? fb : (is_st ? fa : 4'h0));
        wa    = fa;
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller: fetch/decode/execute/mem/writeback sequencing and PC ownership.
// 2-5 cycles per instruction at zero wait; imem/dmem requests hold until ack, each wait adds a cycle.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [3:0]  ctrl_aluop,
    output logic [3:0]  alu_imm4,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic [3:0]  rf_ra1,
    output logic [3:0]  rf_ra2,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [15:0] pc,
    output logic        halted
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic [15:0] ir;
    logic [15:0] ir_nxt;
    logic [15:0] pc_nxt;
    logic [15:0] pc_inc;
    logic        br_taken;

    logic is_r;
    logic is_s;
    logic is_br;
    logic is_ld;
    logic is_st;
    logic is_jmp;
    logic is_halt;

    cpu_decode u_decode (
        .ir      (ir),
        .aluop   (ctrl_aluop),
        .ra1     (rf_ra1),
        .ra2     (rf_ra2),
        .wa      (rf_wa),
        .is_r    (is_r),
        .is_s    (is_s),
        .is_br   (is_br),
        .is_ld   (is_ld),
        .is_st   (is_st),
        .is_jmp  (is_jmp),
        .is_halt (is_halt)
    );

    assign pc_inc    = pc + 16'd1;
    assign imem_addr = pc;
    assign alu_imm4  = ir_c(ir);
    assign halted    = (state == ST_HALT);

    always_comb begin
        br_taken = 1'b0;
        case (ir_op(ir))
            OP_BEQ:  br_taken = alu_zero;
            OP_BLT:  br_taken = alu_neg;
            OP_BGT:  br_taken = !alu_zero && !alu_neg;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (is_jmp) begin
                    pc_nxt    = {pc[15:12], ir[11:0]};
                    state_nxt = ST_FETCH;
                end else if (is_halt) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (is_br) begin
                    // Offset is relative to the following instruction; wraps mod 2^16.
                    pc_nxt    = br_taken ? (pc_inc + sext4(ir_c(ir))) : pc_inc;
                    state_nxt = ST_FETCH;
                end else if (is_ld || is_st) begin
                    state_nxt = ST_MEM;
                end else if (is_r || is_s) begin
                    state_nxt = ST_WB;
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_st;
                if (dmem_ack) begin
                    if (is_st) begin
                        pc_nxt    = pc_inc;
                        state_nxt = ST_FETCH;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                rf_we     = 1'b1;
                rf_wsel   = is_ld;
                pc_nxt    = pc_inc;
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed plus randomized instruction streams checked against an instruction-level reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic [3:0]  ctrl_aluop;
    logic [3:0]  alu_imm4;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic [3:0]  rf_ra1;
    logic [3:0]  rf_ra2;
    logic [3:0]  rf_wa;
    logic        rf_we;
    logic        rf_wsel;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack = 1'b0;
    logic [15:0] pc;
    logic        halted;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] m_pc = 16'h0000;

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .ctrl_aluop (ctrl_aluop),
        .alu_imm4   (alu_imm4),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_wa      (rf_wa),
        .rf_we      (rf_we),
        .rf_wsel    (rf_wsel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction, from the ISA rules alone.
    task automatic model(input logic [15:0] instr, input logic [15:0] pc_in, input bit z, input bit n,
                         input int dw, output int cyc, output int nmem, output bit dwe, output bit we,
                         output bit wsel, output logic [3:0] aluop, output bit k1, output logic [3:0] r1,
                         output bit k2, output logic [3:0] r2, output logic [15:0] npc, output bit hlt);
        int op, a, b, c, off, np;
        bit taken;
        op = int'(instr[15:12]);
        a  = int'(instr[11:8]);
        b  = int'(instr[7:4]);
        c  = int'(instr[3:0]);
        nmem = 0; dwe = 0; we = 0; wsel = 0; k1 = 0; k2 = 0; r1 = 0; r2 = 0; hlt = 0;
        aluop = 4'(op);
        np = int'(pc_in) + 1;
        if (op <= 3) begin
            cyc = 4; we = 1; k1 = 1; r1 = 4'(b); k2 = 1; r2 = 4'(c);
        end else if (op <= 8) begin
            cyc = 4; we = 1; k1 = 1; r1 = 4'(b);
        end else if (op <= 11) begin
            cyc = 3; k1 = 1; r1 = 4'(a); k2 = 1; r2 = 4'(b);
            off = (c >= 8) ? c - 16 : c;
            taken = (op == 9) ? z : ((op == 10) ? n : (!z && !n));
            if (taken) np = int'(pc_in) + 1 + off;
        end else if (op == 12) begin
            cyc = 5 + dw; nmem = dw + 1; we = 1; wsel = 1; k1 = 1; r1 = 4'(b);
        end else if (op == 13) begin
            cyc = 4 + dw; nmem = dw + 1; dwe = 1; k1 = 1; r1 = 4'(b); k2 = 1; r2 = 4'(a);
        end else if (op == 14) begin
            cyc = 2; aluop = 4'h0;
            np = (int'(pc_in) / 4096) * 4096 + int'(instr) % 4096;
        end else begin
            cyc = 2; aluop = 4'h0; hlt = 1; np = int'(pc_in);
        end
        npc = 16'(np & 32'hFFFF);
    endtask

    // Entered on a falling edge while the DUT is fetching; returns on the falling edge of the next fetch.
    task automatic run_instr(input logic [15:0] instr, input int iw, input int dw, input bit z, input bit n);
        int cyc, nmem, c, fetch_bad, pc_bad, stab_bad, dcnt, dwe_bad, wecnt, we_c;
        bit dwe, we, wsel, k1, k2, hlt, fetched, done;
        logic [3:0] aluop, r1, r2, wa_s, s_alu, s_r1, s_r2;
        logic [15:0] npc;
        logic wsel_s;
        model(instr, m_pc, z, n, dw, cyc, nmem, dwe, we, wsel, aluop, k1, r1, k2, r2, npc, hlt);
        c = 0; fetch_bad = 0; pc_bad = 0; stab_bad = 0; dcnt = 0; dwe_bad = 0; wecnt = 0; we_c = -1;
        fetched = 0; done = 0; wa_s = 0; wsel_s = 0; s_alu = 0; s_r1 = 0; s_r2 = 0;
        while (!done && c < 200) begin
            if (fetched && (imem_req === 1'b1 || halted === 1'b1)) begin
                done = 1;
                imem_ack = 1'b0;
                dmem_ack = 1'b0;
            end else begin
                if (pc !== m_pc) pc_bad++;
                if (!fetched) begin
                    if (imem_req !== 1'b1 || imem_addr !== m_pc) fetch_bad++;
                    imem_ack   = (c == iw);
                    imem_rdata = (c == iw) ? instr : 16'($urandom);
                    dmem_ack   = 1'b0;
                    if (c == iw) fetched = 1;
                end else begin
                    imem_ack   = ($urandom_range(0, 3) == 0);
                    imem_rdata = 16'($urandom);
                    if (c == iw + 1) begin
                        chk("aluop", ctrl_aluop, aluop);
                        chk("imm4", alu_imm4, instr[3:0]);
                        if (k1) chk("ra1", rf_ra1, r1);
                        if (k2) chk("ra2", rf_ra2, r2);
                        s_alu = ctrl_aluop; s_r1 = rf_ra1; s_r2 = rf_ra2;
                    end else if (ctrl_aluop !== s_alu || rf_ra1 !== s_r1 || rf_ra2 !== s_r2) begin
                        stab_bad++;
                    end
                    if (dmem_req === 1'b1) begin
                        dcnt++;
                        if (dmem_we !== dwe) dwe_bad++;
                        dmem_ack = (dcnt == dw + 1);
                    end else begin
                        dmem_ack = ($urandom_range(0, 3) == 0);
                    end
                    if (rf_we === 1'b1) begin
                        wecnt++; we_c = c; wa_s = rf_wa; wsel_s = rf_wsel;
                    end
                end
                alu_zero = z;
                alu_neg  = n;
            end
            if (!done) begin
                @(negedge clk);
                c++;
            end
        end
        chk("completed", 32'(done), 32'd1);
        chk("cycles", c, cyc + iw);
        chk("fetch_req_addr", fetch_bad, 0);
        chk("pc_stable", pc_bad, 0);
        chk("decode_stable", stab_bad, 0);
        chk("rf_we_count", wecnt, 32'(we));
        if (we) begin
            chk("wb_cycle", we_c, cyc + iw - 1);
            chk("rf_wa", wa_s, instr[11:8]);
            chk("rf_wsel", 32'(wsel_s), 32'(wsel));
        end
        chk("dmem_cycles", dcnt, nmem);
        chk("dmem_we", dwe_bad, 0);
        chk("halted", 32'(halted), 32'(hlt));
        chk("next_pc", pc, npc);
        m_pc = npc;
    endtask

    initial begin
        int bad, k;
        logic [15:0] ri;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_imem_req", 32'(imem_req), 1);
        chk("rst_rf_we", 32'(rf_we), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_aluop", ctrl_aluop, 0);
        m_pc = 16'h0000;

        run_instr(16'h0123, 0, 0, 0, 0);
        chk("add_pc", pc, 16'h0001);
        run_instr(16'hE005, 0, 0, 0, 0);
        run_instr(16'h912E, 0, 0, 1, 0);
        chk("beq_taken_addr", imem_addr, 16'h0004);
        run_instr(16'hE005, 2, 0, 0, 0);
        run_instr(16'h912E, 0, 0, 0, 0);
        chk("beq_not_taken_addr", imem_addr, 16'h0006);
        run_instr(16'hC4A3, 1, 3, 0, 0);
        run_instr(16'hD4A3, 0, 2, 0, 0);

        for (k = 0; k < 3; k++) begin
            run_instr(16'hEFFF, 0, 0, 0, 0);
            run_instr(16'h0000, 0, 0, 0, 0);
        end
        run_instr(16'hE010, 0, 0, 0, 0);
        chk("at_3010", pc, 16'h3010);
        run_instr(16'hE7FF, 0, 0, 0, 0);
        chk("jump_37ff", pc, 16'h37FF);
        for (k = 3; k < 15; k++) begin
            run_instr(16'hEFFF, 0, 0, 0, 0);
            run_instr(16'h0000, 0, 0, 0, 0);
        end
        run_instr(16'hEFFE, 0, 0, 0, 0);
        run_instr(16'h9001, 0, 0, 1, 0);
        chk("branch_wrap", pc, 16'h0000);

        for (k = 0; k < 150; k++) begin
            ri = 16'($urandom);
            if (ri[15:12] == 4'hF) ri[15:12] = 4'($urandom_range(0, 14));
            run_instr(ri, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        run_instr(16'hF000, 1, 0, 0, 0);
        bad = 0;
        for (k = 0; k < 20; k++) begin
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== m_pc) bad++;
            @(negedge clk);
        end
        chk("halt_absorbing", bad, 0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("halt_rst_pc", pc, 16'h0000);
        chk("halt_rst_halted", 32'(halted), 0);
        chk("halt_rst_imem_req", 32'(imem_req), 1);
        m_pc = 16'h0000;

        run_instr(16'hE123, 0, 0, 0, 0);
        imem_ack = 1'b1;
        imem_rdata = 16'hC4A3;
        @(negedge clk);
        imem_ack = 1'b0;
        k = 0;
        while (dmem_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("midreset_reached_mem", 32'(dmem_req), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midreset_dmem_req", 32'(dmem_req), 0);
        chk("midreset_rf_we", 32'(rf_we), 0);
        chk("midreset_pc", pc, 16'h0000);
        chk("midreset_imem_req", 32'(imem_req), 1);
        m_pc = 16'h0000;
        run_instr(16'h3456, 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control unit for the 16-bit RISC CPU: fetches an instruction word, decodes it, and drives the ALU opcode, register-file addresses and enables, and data-memory requests. It consumes the ALU zero/neg flags to resolve branches and owns the program counter. The unit sits between instruction/data memory and the datapath, which holds the register file and the ALU.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset (word address)
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- imem_req  out  1  instruction fetch request, held until ack
- imem_ack  in  1  fetch done; imem_rdata valid this cycle
- imem_addr  out  16  fetch address (= pc)
- imem_rdata  in  16  instruction word
- ctrl_aluop  out  4  ALU function select
- alu_imm4  out  4  ir[3:0] to the ALU imm4 port
- alu_zero  in  1  ALU zero flag
- alu_neg  in  1  ALU negative flag
- rf_ra1  out  4  register-file read address feeding ALU rs
- rf_ra2  out  4  register-file read address feeding ALU rt / store data
- rf_wa  out  4  write address
- rf_we  out  1  write enable, one-cycle pulse
- rf_wsel  out  1  0 = ALU result, 1 = dmem_rdata
- dmem_req  out  1  data access request, held until ack
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access done
- pc  out  16  current PC
- halted  out  1  high in HALT

## Operation
- Encoding: op = ir[15:12], a = ir[11:8], b = ir[7:4], c = ir[3:0].
- op 0-3 (R-type): rd=a, rs=b, rt=c. op 4-8 (S-type): rd=a, rs=b, imm4=c.
- op 9/A/B (beq/blt/bgt): rs=a, rt=b, c = signed word offset.
- op C (load): rd=a, base=b, imm4=c. op D (store): data reg=a, base=b, imm4=c.
- op E (jump): pc <= {pc[15:12], ir[11:0]}. op F: halt.
- ctrl_aluop = op for op 0-D; 4'b0000 for E/F.
- rf_ra1 = b (R, S, L) or a (B). rf_ra2 = c (R), b (B), a (store).
- Branch taken: beq if alu_zero; blt if alu_neg; bgt if !alu_zero && !alu_neg. Flags are sampled in EXECUTE. ovf is not used.
- Taken target = pc + 1 + sext(c); not taken = pc + 1. All PC arithmetic is mod 2^16, so 16'hFFFF + 1 wraps to 0.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
  - FETCH: imem_req=1. On imem_ack: ir <= imem_rdata, go to DECODE.
  - DECODE:
    - E: update pc, go to FETCH.
    - F: go to HALT.
    - otherwise: go to EXECUTE.
  - EXECUTE:
    - R/S: go to WB.
    - B: update pc, go to FETCH.
    - L: go to MEM.
  - MEM: dmem_req=1, dmem_we=(op==D). On dmem_ack: load goes to WB; store does pc+1 and goes to FETCH. The data-memory address is the ALU result; the datapath holds it stable because ctrl_aluop/ra are held.
  - WB: rf_we=1, rf_wa=a, rf_wsel=(op==C), pc <= pc+1, go to FETCH.
  - HALT: absorbing; only rst_n leaves it.
- ctrl_aluop, rf_ra*, alu_imm4 are decoded from ir and stay stable from DECODE until the next FETCH.

## Timing
- Reset (rst_n=0 at clk edge): state=FETCH, pc=RESET_PC, ir=0, all enables/requests 0, halted=0. Outputs are combinational from state, so imem_req=1 in the first cycle after release.
- Reset asserted mid-access drops imem_req/dmem_req the next cycle; no write or PC update happens.
- Same-cycle ack allowed: req and ack high in one cycle completes the access. Zero-wait cycle counts:
  - R/S: 4
  - load: 5
  - store: 4
  - branch: 3
  - jump: 2
  - halt: 2 to enter HALT
- Each wait cycle adds one cycle. req stays high and address stable until ack. An ack while req=0 is ignored.
- rf_we is high exactly one cycle per R/S/load instruction; never high for B/D/E/F.
- pc changes only on the edge leaving WB, DECODE(E), EXECUTE(B) or MEM(store).

## Structure
- cpu_pkg: opcode localparams (OP_ADD..OP_HALT), state enum ctrl_state_t, field-slice helper functions. The ALU aluop case list moves to these same constants.
- One combinational sub-module, cpu_decode: ir in; aluop, ra1, ra2, wa, class flags (is_r, is_s, is_br, is_ld, is_st, is_jmp, is_halt) out. The FSM and PC live in cpu_ctrl_fsm.

## Test plan
- Reset, imem_rdata=16'h0123 (add r1,r2,r3), ack same cycle: ctrl_aluop=0, ra1=2, ra2=3; rf_we pulse with wa=1 in cycle 4; pc 0 to 1.
- beq 16'h912E at pc=5 with alu_zero=1: next imem_addr=16'h0004 (5+1-2). Same instruction with zero=0: imem_addr=6.
- Load 16'hC4A3 with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles with dmem_we=0, ctrl_aluop=C; then rf_we with wsel=1, wa=4.
- Store 16'hD4A3: dmem_we=1, rf_we never asserts, pc+1.
- Jump 16'hE7FF at pc=16'h3010: pc=16'h37FF after 2 cycles. Branch offset +1 at pc=16'hFFFE taken: pc wraps to 0.
- Halt 16'hF000: halted=1, imem_req stays 0 for 20 cycles; rst_n low for one cycle gives pc=RESET_PC, halted=0, and imem_req=1 in the next cycle.
